// File: rtl/mem_access_arbiter.sv
// Memory access sequencer/arbiter for the multicycle datapath: IDLE -> ACCESS -> WAIT -> ACK.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin among {PC, AluOut, A, B}; Except always wins.
`timescale 1ns/1ps

module mem_access_arbiter #(
  parameter int MEM_LATENCY = 1,
  parameter int CNT_W       = 3
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [4:0] req,
  input  logic [4:0] req_we,
  output logic [2:0] iord_sel,
  output logic       mem_rd,
  output logic       mem_wr,
  output logic [4:0] grant,
  output logic [4:0] ack,
  output logic       busy
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_WAIT   = 2'd2,
    S_ACK    = 2'd3
  } state_t;

  localparam logic [2:0] SRC_PC     = 3'd0;
  localparam logic [2:0] SRC_ALUOUT = 3'd1;
  localparam logic [2:0] SRC_EXCEPT = 3'd2;
  localparam logic [2:0] SRC_A      = 3'd3;
  localparam logic [2:0] SRC_B      = 3'd4;

  localparam logic [CNT_W-1:0] LAT_INIT = CNT_W'(MEM_LATENCY);

  state_t           state_q;
  logic [2:0]       sel_q;
  logic [4:0]       grant_q;
  logic [4:0]       ack_q;
  logic             rd_q;
  logic             wr_q;
  logic             busy_q;
  logic [CNT_W-1:0] cnt_q;

  logic [2:0]       win_sel_d;
  logic [4:0]       win_oh_d;
  logic             win_we_d;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // Pointer indexes the cyclic order PC, AluOut, A, B (0..3) and names the last grantee.
  logic [1:0] rr_ptr_q;
  logic [1:0] rr_idx_d;

  function automatic logic [2:0] rr_src(input logic [1:0] idx);
    case (idx)
      2'd0:    rr_src = SRC_PC;
      2'd1:    rr_src = SRC_ALUOUT;
      2'd2:    rr_src = SRC_A;
      default: rr_src = SRC_B;
    endcase
  endfunction

  always_comb begin
    logic       found;
    logic [1:0] idx;
    win_sel_d = SRC_PC;
    rr_idx_d  = rr_ptr_q;
    found     = 1'b0;
    idx       = rr_ptr_q;
    if (req[SRC_EXCEPT]) begin
      win_sel_d = SRC_EXCEPT;
    end else begin
      for (int k = 1; k <= 4; k++) begin
        idx = rr_ptr_q + 2'(k);
        if (!found && req[rr_src(idx)]) begin
          found     = 1'b1;
          win_sel_d = rr_src(idx);
          rr_idx_d  = idx;
        end
      end
    end
  end
`else
  always_comb begin
    win_sel_d = SRC_PC;
    if (req[SRC_EXCEPT])      win_sel_d = SRC_EXCEPT;
    else if (req[SRC_ALUOUT]) win_sel_d = SRC_ALUOUT;
    else if (req[SRC_A])      win_sel_d = SRC_A;
    else if (req[SRC_B])      win_sel_d = SRC_B;
    else                      win_sel_d = SRC_PC;
  end
`endif

  // PC fetch and exception-vector accesses are always reads.
  always_comb begin
    win_oh_d = 5'b00001 << win_sel_d;
    win_we_d = req_we[win_sel_d] && (win_sel_d != SRC_PC) && (win_sel_d != SRC_EXCEPT);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      sel_q    <= 3'd0;
      grant_q  <= 5'd0;
      ack_q    <= 5'd0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      busy_q   <= 1'b0;
      cnt_q    <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      rr_ptr_q <= 2'd0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          ack_q <= 5'd0;
          if (|req) begin
            state_q <= S_ACCESS;
            grant_q <= win_oh_d;
            sel_q   <= win_sel_d;
            rd_q    <= ~win_we_d;
            wr_q    <= win_we_d;
            busy_q  <= 1'b1;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            if (!req[SRC_EXCEPT]) rr_ptr_q <= rr_idx_d;
`endif
          end else begin
            sel_q <= 3'd0;
          end
        end
        S_ACCESS: begin
          rd_q    <= 1'b0;
          wr_q    <= 1'b0;
          cnt_q   <= LAT_INIT;
          state_q <= S_WAIT;
        end
        // Counter holds the remaining wait cycles; the last one launches ACK.
        S_WAIT: begin
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_q <= S_ACK;
            ack_q   <= grant_q;
          end
        end
        S_ACK: begin
          ack_q   <= 5'd0;
          grant_q <= 5'd0;
          sel_q   <= 3'd0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign iord_sel = sel_q;
  assign mem_rd   = rd_q;
  assign mem_wr   = wr_q;
  assign grant    = grant_q;
  assign ack      = ack_q;
  assign busy     = busy_q;

endmodule
